// File: rtl/button_conditioner_pkg.sv
// Shared constants for the front-panel button conditioner: button indices
// and the per-button debounce state encoding.
package button_conditioner_pkg;

  localparam int BTN_RESET   = 0;
  localparam int BTN_FREQ    = 1;
  localparam int BTN_CLKMODE = 2;
  localparam int BTN_MANUAL  = 3;

  localparam int NUM_BUTTONS = BTN_MANUAL + 1;

  typedef enum logic [1:0] {
    ST_RELEASED        = 2'd0,
    ST_CONFIRM_PRESS   = 2'd1,
    ST_PRESSED         = 2'd2,
    ST_CONFIRM_RELEASE = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer, four-state debounce FSM with a stable-sample
// counter, and optional auto-repeat enabled by the BUTTON_AUTOREPEAT_EN macro.
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clock_100mhz,
  input  logic reset_n,
  input  logic button_raw,
  output logic button_level,
  output logic button_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_debounce: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [1:0]       sync_q;
  logic             sample;
  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_d, press_d, repeat_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock_100mhz) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], button_raw};
  end

  assign sample = sync_q[1];

  always_ff @(posedge clock_100mhz) begin
    if (!reset_n) begin
      state_q      <= ST_RELEASED;
      count_q      <= '0;
      button_level <= 1'b1;
      button_press <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      button_level <= level_d;
      button_press <= press_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_RELEASED: begin
        if (!sample) begin
          state_d = ST_CONFIRM_PRESS;
          count_d = CNT_ONE;
        end
      end
      ST_CONFIRM_PRESS: begin
        if (sample) begin
          state_d = ST_RELEASED;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_LAST) state_d = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (sample) begin
          state_d = ST_CONFIRM_RELEASE;
          count_d = CNT_ONE;
        end
      end
      ST_CONFIRM_RELEASE: begin
        if (!sample) begin
          state_d = ST_PRESSED;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_LAST) state_d = ST_RELEASED;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    level_d = !(state_d == ST_PRESSED || state_d == ST_CONFIRM_RELEASE);
    press_d = ((state_q == ST_CONFIRM_PRESS) && (state_d == ST_PRESSED)) || repeat_fire;
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] repeat_q;
  logic             holding;

  // The repeat phase restarts whenever the button leaves the settled PRESSED state.
  assign holding     = (state_q == ST_PRESSED) && (state_d == ST_PRESSED);
  assign repeat_fire = holding && (repeat_q == REP_LAST);

  always_ff @(posedge clock_100mhz) begin
    if (!reset_n || !holding || repeat_fire) repeat_q <= '0;
    else                                     repeat_q <= repeat_q + REP_W'(1);
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four active-low front-panel pushbuttons into debounced levels
// and press pulses; BUTTON_AUTOREPEAT_EN adds auto-repeat pulses while held.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clock_100mhz,
  input  logic       reset_n,
  input  logic [3:0] buttons_raw,
  output logic [3:0] buttons_level,
  output logic [3:0] buttons_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_debounce (
      .clock_100mhz(clock_100mhz),
      .reset_n     (reset_n),
      .button_raw  (buttons_raw[i]),
      .button_level(buttons_level[i]),
      .button_press(buttons_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20;
// expectations track BUTTON_AUTOREPEAT_EN when it is defined for the build.
module tb_button_conditioner;

  localparam int D = 8;
  localparam int R = 20;

  logic       clock_100mhz = 1'b0;
  logic       reset_n      = 1'b0;
  logic [3:0] buttons_raw  = 4'hF;
  logic [3:0] buttons_level;
  logic [3:0] buttons_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clock_100mhz (clock_100mhz),
    .reset_n      (reset_n),
    .buttons_raw  (buttons_raw),
    .buttons_level(buttons_level),
    .buttons_press(buttons_press)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  typedef struct {
    logic [3:0] raw;
    logic       rst_n;
    logic [3:0] level;
    logic [3:0] press;
  } vec_t;

  vec_t vecs[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: a level flips once the synchronized input has disagreed
  // with it for D consecutive samples; the sync path is a two-sample delay.
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_level = 4'hF, m_press = 4'h0;
  int         m_run[4];
`ifdef BUTTON_AUTOREPEAT_EN
  int         m_age[4];
`endif

  int step_no = 0;
  int press_count[4];
  int last_press_step[4];
  int fall_count[4];
  int rise_count[4];
  logic [3:0] prev_level = 4'hF;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_step(input logic [3:0] raw, input logic rst);
    logic [3:0] smp;
`ifdef BUTTON_AUTOREPEAT_EN
    logic [3:0] settled_low;
    for (int i = 0; i < 4; i++) settled_low[i] = !m_level[i] && (m_run[i] == 0);
`endif
    if (!rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_level = 4'hF; m_press = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0;
`ifdef BUTTON_AUTOREPEAT_EN
        m_age[i] = 0;
`endif
      end
    end else begin
      smp     = m_s2;
      m_s2    = m_s1;
      m_s1    = raw;
      m_press = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (smp[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_level[i] = smp[i];
            m_run[i]   = 0;
            m_press[i] = !smp[i];
          end
        end else begin
          m_run[i] = 0;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        if (settled_low[i] && !smp[i]) begin
          m_age[i]++;
          if (m_age[i] == R) begin
            m_press[i] = 1'b1;
            m_age[i]   = 0;
          end
        end else begin
          m_age[i] = 0;
        end
`endif
      end
    end
  endtask

  task automatic drive(input logic [3:0] raw, input logic rst);
    buttons_raw = raw;
    reset_n     = rst;
    @(posedge clock_100mhz);
    model_step(raw, rst);
    #1;
    step_no++;
    for (int i = 0; i < 4; i++) begin
      if (buttons_press[i]) begin
        press_count[i]++;
        last_press_step[i] = step_no;
      end
      if (prev_level[i] && !buttons_level[i]) fall_count[i]++;
      if (!prev_level[i] && buttons_level[i]) rise_count[i]++;
    end
    prev_level = buttons_level;
  endtask

  task automatic step(input logic [3:0] raw, input logic rst, input string name);
    drive(raw, rst);
    check(name, {24'h0, buttons_level, buttons_press}, {24'h0, m_level, m_press});
  endtask

  task automatic run(input logic [3:0] raw, input int n, input string name);
    for (int k = 0; k < n; k++) step(raw, 1'b1, name);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      press_count[i] = 0; last_press_step[i] = -1; fall_count[i] = 0; rise_count[i] = 0;
    end
  endtask

  task automatic add_vec(input logic [3:0] raw, input logic rst, input logic [3:0] lvl, input logic [3:0] prs);
    vec_t v;
    v.raw = raw; v.rst_n = rst; v.level = lvl; v.press = prs;
    vecs.push_back(v);
  endtask

  initial begin
    int s;
    int exp_pulses;
    int exp_last;
    int hold_left[4];
    logic [3:0] rnd_raw;

    // Reset, then hold bit3: raw applied at step k is sampled by the FSM from step k+2,
    // so the eighth stable sample lands and the pulse shows at step k+9.
    add_vec(4'hF, 1'b0, 4'hF, 4'h0);
    add_vec(4'hF, 1'b0, 4'hF, 4'h0);
    for (int k = 0; k < 8; k++) add_vec(4'h7, 1'b1, 4'hF, 4'h0);
    add_vec(4'h7, 1'b1, 4'hF, 4'h0);
    add_vec(4'h7, 1'b1, 4'h7, 4'h8);
    for (int k = 0; k < 3; k++) add_vec(4'h7, 1'b1, 4'h7, 4'h0);

    clear_stats();
    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].raw, vecs[v].rst_n);
      check($sformatf("vec%0d", v), {24'h0, buttons_level, buttons_press},
            {24'h0, vecs[v].level, vecs[v].press});
    end
    check("vec_press3_count", press_count[3], 1);
    run(4'hF, 12, "release3");
    check("release3_level", {28'h0, buttons_level}, 32'hF);

    // Bit1 bounce: low 5 / high 1 / low 12.
    clear_stats();
    run(4'hD, 5, "bounce1_a");
    run(4'hF, 1, "bounce1_b");
    s = step_no + 1;
    run(4'hD, 12, "bounce1_c");
    check("bounce1_count", press_count[1], 1);
    check("bounce1_time", last_press_step[1], s + 9);
    check("bounce1_falls", fall_count[1], 1);
    run(4'hF, 12, "bounce1_rel");

    // Bit2 release bounce: held, high 3, low again, then clean release.
    clear_stats();
    run(4'hB, 12, "hold2");
    run(4'hF, 3, "hold2_glitch");
    run(4'hB, 10, "hold2_again");
    check("hold2_rises", rise_count[2], 0);
    check("hold2_level", {31'h0, buttons_level[2]}, 0);
    run(4'hF, 12, "rel2");
    check("rel2_level", {31'h0, buttons_level[2]}, 1);
    check("rel2_press_count", press_count[2], 1);

    // Bits 0 and 3 together, then reset at confirm count 5.
    clear_stats();
    s = step_no + 1;
    run(4'h6, 12, "dual");
    check("dual_time0", last_press_step[0], s + 9);
    check("dual_time3", last_press_step[3], s + 9);
    run(4'hF, 12, "dual_rel");
    clear_stats();
    run(4'h6, 7, "dual_confirm");
    step(4'h6, 1'b0, "dual_reset");
    check("dual_reset_out", {24'h0, buttons_level, buttons_press}, 32'hF0);
    step(4'h6, 1'b0, "dual_reset");
    check("dual_reset_nopulse", press_count[0] + press_count[3], 0);
    s = step_no + 1;
    run(4'h6, 12, "dual_restart");
    check("dual_restart_time0", last_press_step[0], s + 9);
    check("dual_restart_time3", last_press_step[3], s + 9);
    check("dual_restart_count", press_count[0] + press_count[3], 2);
    run(4'hF, 12, "dual_restart_rel");

    // Long hold on bit3: 70 cycles past acceptance, then release.
`ifdef BUTTON_AUTOREPEAT_EN
    exp_pulses = 4;
    exp_last   = 9 + 60;
`else
    exp_pulses = 1;
    exp_last   = 9;
`endif
    clear_stats();
    s = step_no + 1;
    run(4'h7, 9 + 70, "long3");
    check("long3_count", press_count[3], exp_pulses);
    check("long3_last", last_press_step[3], s + exp_last);
    run(4'hF, 30, "long3_rel");
    check("long3_rel_count", press_count[3], exp_pulses);

    // Random bouncing levels with occasional resets, checked against the model.
    for (int i = 0; i < 4; i++) hold_left[i] = 0;
    rnd_raw = 4'hF;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold_left[i] == 0) begin
          rnd_raw[i]   = 1'($urandom_range(1, 0));
          hold_left[i] = $urandom_range(12, 1);
        end
        hold_left[i]--;
      end
      step(rnd_raw, ($urandom_range(149, 0) != 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count required to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 25000000, auto-repeat period in cycles; legal range >= 2; used only when BUTTON_AUTOREPEAT_EN is defined.
REQ-003 clock_100mhz  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 buttons_raw  input  4  asynchronous active-low pushbuttons: [0] reset, [1] frequency mode, [2] clock mode, [3] manual clock.
REQ-006 buttons_level  output  4  debounced active-low levels, same bit order; drive the clock-control button inputs.
REQ-007 buttons_press  output  4  one-cycle active-high pulse per accepted press, same bit order.

Function
REQ-008 Each bit SHALL pass through a 2-flop synchronizer before any other logic; the synchronizer flops SHALL reset to 1.
REQ-009 Each bit SHALL run an independent FSM with states RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE, and a saturating counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-010 RELEASED: synchronized input 0 -> CONFIRM_PRESS with counter cleared to 1; otherwise stay.
REQ-011 CONFIRM_PRESS: input 0 -> counter increments; when the counter reaches DEBOUNCE_CYCLES, go to PRESSED. Input 1 -> RELEASED with counter cleared (bounce rejected).
REQ-012 PRESSED: input 1 -> CONFIRM_RELEASE with counter cleared to 1; otherwise stay.
REQ-013 CONFIRM_RELEASE: mirrors REQ-011 with input polarity inverted; completion -> RELEASED; a 0 sample -> PRESSED.
REQ-014 buttons_level[i] SHALL be 0 exactly while FSM i is in PRESSED or CONFIRM_RELEASE, and 1 otherwise, registered.
REQ-015 If the synchronized input first reads 0 at cycle t and stays 0, buttons_level[i] SHALL fall and buttons_press[i] SHALL pulse at cycle t+DEBOUNCE_CYCLES.
REQ-016 buttons_press[i] SHALL be high for exactly one cycle per CONFIRM_PRESS->PRESSED transition; a held button produces no further pulses except as REQ-021 allows.
REQ-017 Any bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no change on either output.
REQ-018 Bits SHALL be fully independent; simultaneous presses on several bits SHALL yield pulses in the same cycle when their input timing is identical.

Reset
REQ-019 While reset_n=0 at a clock edge: all FSMs go to RELEASED, counters go to 0, buttons_level=4'b1111, buttons_press=4'b0000, and the repeat counters clear. Reset mid-confirm or mid-press SHALL discard that state without emitting a pulse.
REQ-020 After reset_n rises, a button still held SHALL be treated as a new press, per REQ-015.

Configuration
REQ-021 With BUTTON_AUTOREPEAT_EN defined: while FSM i is in PRESSED, buttons_press[i] SHALL additionally pulse every REQ-repeat interval of REPEAT_CYCLES cycles after the initial pulse. A per-bit repeat counter SHALL clear on leaving PRESSED. buttons_level is unaffected.
REQ-022 Without BUTTON_AUTOREPEAT_EN: no repeat logic is synthesized, and REPEAT_CYCLES is ignored.

Structure
REQ-023 The button index constants (BTN_RESET=0, BTN_FREQ=1, BTN_CLKMODE=2, BTN_MANUAL=3) and the FSM state encodings SHALL live in the shared config/constants include.
REQ-024 Per-bit logic (synchronizer, FSM, counter, optional repeat) SHALL be a sub-module button_debounce, instantiated 4 times by a generate loop.

Verification
All scenarios use DEBOUNCE_CYCLES=8 and REPEAT_CYCLES=20.
REQ-025 Reset with buttons_raw=4'hF -> buttons_level=4'hF and buttons_press=0; hold bit3 low -> a single press[3] pulse and level[3]=0 exactly 8 cycles after the synchronized fall.
REQ-026 Bit1 bounces with the pattern low 5 / high 1 / low 12 -> exactly one press[1] pulse, timed 8 cycles after the start of the final low run; no glitch on level[1].
REQ-027 Bit2 is held, then released with a high pulse of 3 cycles before going low again -> level[2] stays 0 throughout; a clean high for 8 cycles -> level[2]=1 and no press pulse.
REQ-028 Bits 0 and 3 fall on the same cycle -> press[0] and press[3] pulse in the same cycle; reset_n is asserted at confirm count 5 -> no pulse, and the press restarts after reset release.
REQ-029 With BUTTON_AUTOREPEAT_EN, hold bit3 for 70 cycles past acceptance -> pulses at +0, +20, +40, +60; on release, no further pulses. Without the macro -> exactly one pulse.
